// File: rtl/regbus_pkg.sv
// Shared types and constants for the peripheral register-bus initiator.
package regbus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RCAP = 3'd2,
    WR   = 3'd3,
    ACK  = 3'd4
  } regbus_state_e;

  localparam logic [15:0] REGBUS_BASE_DEFAULT = 16'o177700;

  localparam logic [3:0] REG_TIMER_RELOAD = 4'o06;
  localparam logic [3:0] REG_TIMER_COUNT  = 4'o10;
  localparam logic [3:0] REG_TIMER_CTRL   = 4'o12;

  // Insert the CPU byte into the word read back from the peripheral.
  function automatic logic [15:0] merge_byte(input logic        odd,
                                             input logic [15:0] wdata,
                                             input logic [15:0] rdata);
    logic [15:0] res;
    if (odd) begin
      res = {wdata[15:8], rdata[7:0]};
    end else begin
      res = {rdata[15:8], wdata[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/regbus_master.sv
// CPU-to-peripheral register strobe initiator for the I/O page window.
// Byte writes become read-modify-write cycles when REGBUS_BYTE_RMW_EN is defined.
import regbus_pkg::*;

module regbus_master #(
  parameter logic [15:0] BASE = REGBUS_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        regwr,
  output logic        regrd,
  output logic [3:0]  addr,
  output logic [15:0] per_wdata,
  input  logic [15:0] per_rdata
);

  regbus_state_e state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [15:0]   per_wdata_q, per_wdata_d;
  logic [15:0]   cpu_rdata_q, cpu_rdata_d;
  logic          regrd_q, regrd_d;
  logic          regwr_q, regwr_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          hit_s;
`ifdef REGBUS_BYTE_RMW_EN
  logic          rmw_q, rmw_d;
  logic          odd_q, odd_d;
`else
  logic          unused_s;
  assign unused_s = ^{cpu_byte, cpu_addr[0]};
`endif

  assign hit_s = (cpu_addr[15:4] == BASE[15:4]);

  // Next-state, datapath latches, and strobes decoded from the next state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    per_wdata_d = per_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef REGBUS_BYTE_RMW_EN
    rmw_d       = rmw_q;
    odd_d       = odd_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req && hit_s && !cpu_ack_q) begin
          addr_d      = {cpu_addr[3:1], 1'b0};
          per_wdata_d = cpu_wdata;
`ifdef REGBUS_BYTE_RMW_EN
          rmw_d       = cpu_we & cpu_byte;
          odd_d       = cpu_addr[0];
          state_d     = (!cpu_we || cpu_byte) ? RD : WR;
`else
          state_d     = cpu_we ? WR : RD;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (ce) begin
          state_d = RCAP;
        end else begin
          state_d = RD;
        end
      end
      RCAP: begin
        cpu_rdata_d = per_rdata;
`ifdef REGBUS_BYTE_RMW_EN
        if (rmw_q) begin
          per_wdata_d = merge_byte(odd_q, per_wdata_q, per_rdata);
          state_d     = WR;
        end else begin
          state_d = ACK;
        end
`else
        state_d = ACK;
`endif
      end
      WR: begin
        if (ce) begin
          state_d = ACK;
        end else begin
          state_d = WR;
        end
      end
      ACK: begin
        // The request level, not the ack, decides when the handshake closes.
        if (!cpu_req) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    regrd_d   = (state_d == RD);
    regwr_d   = (state_d == WR);
    cpu_ack_d = (state_d == ACK);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= 4'd0;
      per_wdata_q <= 16'd0;
      cpu_rdata_q <= 16'd0;
      regrd_q     <= 1'b0;
      regwr_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
`ifdef REGBUS_BYTE_RMW_EN
      rmw_q       <= 1'b0;
      odd_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      per_wdata_q <= per_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      regrd_q     <= regrd_d;
      regwr_q     <= regwr_d;
      cpu_ack_q   <= cpu_ack_d;
`ifdef REGBUS_BYTE_RMW_EN
      rmw_q       <= rmw_d;
      odd_q       <= odd_d;
`endif
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign regwr     = regwr_q;
  assign regrd     = regrd_q;
  assign addr      = addr_q;
  assign per_wdata = per_wdata_q;

endmodule

// File: tb/tb_regbus_master.sv
// Table-driven bench for regbus_master with a small peripheral read model.
module tb_regbus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_byte = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic [15:0] cpu_wdata = 16'd0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        regwr;
  logic        regrd;
  logic [3:0]  addr;
  logic [15:0] per_wdata;
  logic [15:0] per_rdata = 16'hDEAD;

  logic [15:0] per_val = 16'h0000;
  int          ce_period = 1;
  int          ce_cnt = 0;

  int rd_ce_cnt = 0, wr_ce_cnt = 0, rd_hi_cnt = 0, wr_hi_cnt = 0;
  int both_cnt = 0, ack_hi_cnt = 0;
  logic [15:0] last_wd = 16'd0;

  int checks = 0;
  int errors = 0;

  regbus_master dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_byte(cpu_byte), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .regwr(regwr), .regrd(regrd),
    .addr(addr), .per_wdata(per_wdata), .per_rdata(per_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ce_cnt = ce_cnt + 1;
    ce = ((ce_cnt % ce_period) == 0);
  end

  // Peripheral: data_o follows the read strobe one ce edge later.
  always @(posedge clk) begin
    if (ce && regrd) per_rdata <= per_val;
    else if (!cpu_req) per_rdata <= 16'hDEAD;
  end

  always @(negedge clk) begin
    if (ce && regrd) rd_ce_cnt <= rd_ce_cnt + 1;
    if (ce && regwr) begin
      wr_ce_cnt <= wr_ce_cnt + 1;
      last_wd   <= per_wdata;
    end
    if (regrd) rd_hi_cnt <= rd_hi_cnt + 1;
    if (regwr) wr_hi_cnt <= wr_hi_cnt + 1;
    if (regrd && regwr) both_cnt <= both_cnt + 1;
    if (cpu_ack) ack_hi_cnt <= ack_hi_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic bt, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] pv, output int lat);
    per_val   = pv;
    cpu_we    = we;
    cpu_byte  = bt;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ack) break;
    end
    if (!cpu_ack) lat = -1;
  endtask

  task automatic release_req(input string name);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk(name, {31'd0, cpu_ack}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic        bt;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] pv;
    int          n_rd;
    int          n_wr;
    logic [15:0] e_wd;
    logic [3:0]  e_addr;
    logic [15:0] e_rd;
    int          e_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int rd0, wr0, rh0, wh0, ah0;

    vecs[0] = '{we:1'b1, bt:1'b0, a:16'o177706, wd:16'o1234, pv:16'h0000,
                n_rd:0, n_wr:1, e_wd:16'o1234, e_addr:4'o06, e_rd:16'h0000, e_lat:2};
    vecs[1] = '{we:1'b0, bt:1'b0, a:16'o177710, wd:16'h0000, pv:16'hBEEF,
                n_rd:1, n_wr:0, e_wd:16'h0000, e_addr:4'o10, e_rd:16'hBEEF, e_lat:3};
    vecs[2] = '{we:1'b0, bt:1'b1, a:16'o177713, wd:16'h0000, pv:16'h5A5A,
                n_rd:1, n_wr:0, e_wd:16'h0000, e_addr:4'o12, e_rd:16'h5A5A, e_lat:3};
`ifdef REGBUS_BYTE_RMW_EN
    vecs[3] = '{we:1'b1, bt:1'b1, a:16'o177707, wd:16'hAB00, pv:16'h1234,
                n_rd:1, n_wr:1, e_wd:16'hAB34, e_addr:4'o06, e_rd:16'h1234, e_lat:4};
    vecs[4] = '{we:1'b1, bt:1'b1, a:16'o177716, wd:16'h00CD, pv:16'h9876,
                n_rd:1, n_wr:1, e_wd:16'h98CD, e_addr:4'o16, e_rd:16'h9876, e_lat:4};
    vecs[5] = '{we:1'b1, bt:1'b0, a:16'o177700, wd:16'hFFFF, pv:16'h1111,
                n_rd:0, n_wr:1, e_wd:16'hFFFF, e_addr:4'o00, e_rd:16'h9876, e_lat:2};
`else
    vecs[3] = '{we:1'b1, bt:1'b1, a:16'o177707, wd:16'hAB00, pv:16'h1234,
                n_rd:0, n_wr:1, e_wd:16'hAB00, e_addr:4'o06, e_rd:16'h5A5A, e_lat:2};
    vecs[4] = '{we:1'b1, bt:1'b1, a:16'o177716, wd:16'h00CD, pv:16'h9876,
                n_rd:0, n_wr:1, e_wd:16'h00CD, e_addr:4'o16, e_rd:16'h5A5A, e_lat:2};
    vecs[5] = '{we:1'b1, bt:1'b0, a:16'o177700, wd:16'hFFFF, pv:16'h1111,
                n_rd:0, n_wr:1, e_wd:16'hFFFF, e_addr:4'o00, e_rd:16'h5A5A, e_lat:2};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_regwr", {31'd0, regwr}, 32'd0);
    chk("rst_regrd", {31'd0, regrd}, 32'd0);
    chk("rst_addr", {28'd0, addr}, 32'd0);
    chk("rst_per_wdata", {16'd0, per_wdata}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, ce every cycle
    for (int v = 0; v < 6; v++) begin
      rd0 = rd_ce_cnt; wr0 = wr_ce_cnt; wh0 = wr_hi_cnt;
      do_txn(vecs[v].we, vecs[v].bt, vecs[v].a, vecs[v].wd, vecs[v].pv, lat);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].e_lat);
      chk($sformatf("v%0d_regrd_count", v), rd_ce_cnt - rd0, vecs[v].n_rd);
      chk($sformatf("v%0d_regwr_count", v), wr_ce_cnt - wr0, vecs[v].n_wr);
      chk($sformatf("v%0d_regwr_cycles", v), wr_hi_cnt - wh0, vecs[v].n_wr);
      chk($sformatf("v%0d_addr", v), {28'd0, addr}, {28'd0, vecs[v].e_addr});
      chk($sformatf("v%0d_cpu_rdata", v), {16'd0, cpu_rdata}, {16'd0, vecs[v].e_rd});
      if (vecs[v].n_wr > 0)
        chk($sformatf("v%0d_per_wdata", v), {16'd0, last_wd}, {16'd0, vecs[v].e_wd});
      release_req($sformatf("v%0d_ack_fall", v));
    end

    // Read with ce every 4th clock
    ce_period = 4;
    rd0 = rd_ce_cnt; rh0 = rd_hi_cnt;
    do_txn(1'b0, 1'b0, 16'o177710, 16'h0000, 16'hBEEF, lat);
    chk("sparse_latency_range", {31'd0, (lat >= 3 && lat <= 7)}, 32'd1);
    chk("sparse_regrd_ce_edges", rd_ce_cnt - rd0, 1);
    chk("sparse_regrd_seen", {31'd0, (rd_hi_cnt - rh0) >= 1}, 32'd1);
    chk("sparse_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, 16'hBEEF});
    release_req("sparse_ack_fall");
    ce_period = 1;
    repeat (2) @(posedge clk);
    #1;

    // Miss outside the window
    rd0 = rd_ce_cnt; wr0 = wr_ce_cnt; rh0 = rd_hi_cnt; wh0 = wr_hi_cnt; ah0 = ack_hi_cnt;
    cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'o177600; cpu_req = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("miss_regrd", rd_hi_cnt - rh0, 0);
    chk("miss_regwr", wr_hi_cnt - wh0, 0);
    chk("miss_ack", ack_hi_cnt - ah0, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    do_txn(1'b1, 1'b0, 16'o177706, 16'h0101, 16'h0000, lat);
    chk("after_miss_latency", lat, 2);
    release_req("after_miss_ack_fall");

    // Reset asserted while in RD
    per_val = 16'h7777; cpu_we = 1'b0; cpu_byte = 1'b0;
    cpu_addr = 16'o177710; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("mid_read_in_rd", {31'd0, regrd}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_read_regrd_drop", {31'd0, regrd}, 32'd0);
    ah0 = ack_hi_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_read_no_ack", ack_hi_cnt - ah0, 0);
    chk("mid_read_rdata_cleared", {16'd0, cpu_rdata}, 32'd0);
    rd0 = rd_ce_cnt;
    do_txn(1'b0, 1'b0, 16'o177712, 16'h0000, 16'h0F0F, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_regrd_count", rd_ce_cnt - rd0, 1);
    chk("post_rst_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, 16'h0F0F});
    chk("post_rst_addr", {28'd0, addr}, {28'd0, 4'o12});
    release_req("post_rst_ack_fall");

    // Request held long after ack
    rd0 = rd_ce_cnt; wr0 = wr_ce_cnt;
    do_txn(1'b1, 1'b0, 16'o177712, 16'h4321, 16'h0000, lat);
    repeat (10) @(posedge clk);
    #1;
    chk("held_ack_high", {31'd0, cpu_ack}, 32'd1);
    chk("held_regwr_count", wr_ce_cnt - wr0, 1);
    chk("held_regrd_count", rd_ce_cnt - rd0, 0);
    chk("held_per_wdata", {16'd0, last_wd}, {16'd0, 16'h4321});
    release_req("held_ack_fall");

    chk("strobes_never_together", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
